// File: rtl/md_pkg.sv
// md_pkg: shared encodings, default latencies and predicates for the multiply/divide unit.
package md_pkg;
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  function automatic logic is_md_op(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd8;
  endfunction
  function automatic logic is_arith_op(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd4;
  endfunction
  function automatic logic is_div_op(input logic [3:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit {HI,LO} result generation for MULT/MULTU/DIV/DIVU.
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_div0
);
  logic [31:0] w_bs;
  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic        w_ovf;
  assign w_ovf  = i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF;
  // Dividing by 1 instead yields the required 0x80000000 / 0 and keeps the divider total.
  assign w_bs   = (i_b == 32'd0 || w_ovf) ? 32'd1 : i_b;
  assign w_smul = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_umul = {32'd0, i_a} * {32'd0, i_b};
  assign o_div0 = is_div_op(i_op) && i_b == 32'd0;
  always_comb begin
    o_res = 64'd0;
    o_res = i_op == MD_MULT  ? w_smul :
            i_op == MD_MULTU ? w_umul :
            i_op == MD_DIV   ? {32'($signed(i_a) % $signed(w_bs)), 32'($signed(i_a) / $signed(w_bs))} :
            i_op == MD_DIVU  ? {i_a % w_bs, i_a / w_bs} : 64'd0;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding HI/LO, with busy countdown and MT/MF access.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        start,
  output logic [31:0] MD_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [CW-1:0] r_count;
  logic [31:0]   r_pend_hi, r_pend_lo, r_hi, r_lo;
  logic          r_busy, r_div0;
  logic [63:0]   w_res;
  logic          w_div0;
  md_calc u_calc (
    .i_op  (md_op),
    .i_a   (A),
    .i_b   (B),
    .o_res (w_res),
    .o_div0(w_div0)
  );
  assign start  = is_arith_op(md_op) && !cancel && !r_busy;
  assign busy   = r_busy;
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign MD_out = md_op == MD_MFHI ? r_hi : r_lo;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (start) begin
      r_busy    <= 1'b1;
      r_count   <= is_div_op(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      r_pend_hi <= w_res[63:32];
      r_pend_lo <= w_res[31:0];
      r_div0    <= w_div0;
    end else if (r_busy) begin
      r_count <= r_count - 1'b1;
      if (r_count == CW'(1)) begin
        r_busy <= 1'b0;
        if (!r_div0) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
    end else if (!cancel) begin
      if (md_op == MD_MTHI) r_hi <= A;
      if (md_op == MD_MTLO) r_lo <= A;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed stimulus with a commit scoreboard checked by an independent monitor.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  md_op = 4'd0;
  logic        cancel = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        busy, start;
  logic [31:0] MD_out, HI, LO;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, bcnt = 0;
  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .cancel(cancel),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .start (start),
    .MD_out(MD_out),
    .HI    (HI),
    .LO    (LO)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Monitor: a falling busy outside reset is a commit; compare it with the oldest expectation.
  always @(negedge clk) begin
    if (!reset) bcnt = 0;
    else if (busy) bcnt++;
    else if (bcnt > 0) begin
      if (q.size() == 0) chk("unexpected_commit", 32'(bcnt), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("commit_busy_cycles", 32'(bcnt), 32'(e.cyc));
        chk("commit_HI", HI, e.hi);
        chk("commit_LO", LO, e.lo);
      end
      bcnt = 0;
    end
  end
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic exp_start);
    md_op = op;
    A = a;
    B = b;
    cancel = c;
    #1 chk("start", {31'd0, start}, {31'd0, exp_start});
    @(posedge clk);
    #1;
    md_op = 4'd0;
    cancel = 1'b0;
  endtask
  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.cyc = cyc;
    q.push_back(e);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask
  task automatic read_md(input logic [3:0] op, input string nm, input logic [31:0] exp);
    md_op = op;
    #1 chk(nm, MD_out, exp);
    md_op = 4'd0;
  endtask
  initial begin
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_LO", LO, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    push(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    wait_idle();
    read_md(4'd8, "mult_mflo", 32'hFFFF_FFFE);
    push(32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    wait_idle();
    read_md(4'd7, "multu_mfhi", 32'h0000_0001);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    wait_idle();
    push(32'd1, 32'd3, 10);
    issue(4'd4, 32'd7, 32'd2, 1'b0, 1'b1);
    wait_idle();
    issue(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    chk("mthi", HI, 32'h1234_5678);
    push(32'h1234_5678, 32'd3, 10);
    issue(4'd4, 32'd9, 32'd0, 1'b0, 1'b1);
    wait_idle();
    push(32'd0, 32'h8000_0000, 10);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_idle();
    push(32'd1, 32'hFFFF_FFFD, 10);
    issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1);
    wait_idle();
    issue(4'd1, 32'd5, 32'd6, 1'b1, 1'b0);
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_HI", HI, 32'd1);
    chk("cancel_LO", LO, 32'hFFFF_FFFD);
    issue(4'd6, 32'h0000_AAAA, 32'd0, 1'b1, 1'b0);
    chk("mtlo_cancel", LO, 32'hFFFF_FFFD);
    issue(4'd6, 32'h0000_0055, 32'd0, 1'b0, 1'b0);
    chk("mtlo", LO, 32'h0000_0055);
    push(32'd0, 32'd12, 5);
    issue(4'd1, 32'd3, 32'd4, 1'b0, 1'b1);
    issue(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    chk("mtlo_busy", LO, 32'h0000_0055);
    issue(4'd1, 32'd9, 32'd9, 1'b1, 1'b0);
    issue(4'd2, 32'd9, 32'd9, 1'b0, 1'b0);
    wait_idle();
    issue(4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_HI", HI, 32'd0);
    chk("rst_mid_LO", LO, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_HI", HI, 32'd0);
    chk("post_rst_LO", LO, 32'd0);
    chk("pending_commits", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage, holding the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO.
- Drives MD_out, the E-stage HI/LO read value consumed by the operand-forwarding mux. The registered copy becomes MDO_M in M.
- Drives busy, which the hazard unit uses to stall D-stage HI/LO instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- md_op  input  4  E-stage operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9-15 treated as NONE
- cancel  input  1  exception/flush this cycle; suppresses any start or HI/LO write from md_op
- A  input  32  forwarded rs operand (MFRSE)
- B  input  32  forwarded rt operand (MFRTE)
- busy  output  1  a multiply/divide is in flight
- start  output  1  combinational: md_op in 1..4, !cancel, !busy
- MD_out  output  32  combinational: HI when md_op==MFHI, otherwise LO
- HI  output  32  architectural HI (debug/trace)
- LO  output  32  architectural LO (debug/trace)

Behaviour:
- Reset (reset==0, async): HI=0, LO=0, busy=0, count=0, pending result cleared.
- Start, at the edge where start==1:
  - Compute the 64-bit result from A/B into pending registers (pend_hi, pend_lo).
  - busy<=1; count<=MULT_CYCLES or DIV_CYCLES.
- Arithmetic:
  - MULT: signed 32x32 -> {HI,LO}.
  - MULTU: unsigned 32x32 -> {HI,LO}.
  - DIV: LO=quotient, HI=remainder, signed. Truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Busy countdown:
  - Each edge with busy: count<=count-1.
  - At the edge where count==1: HI<=pend_hi, LO<=pend_lo, busy<=0.
  - busy is therefore high for exactly N cycles after the start edge. New HI/LO are visible on MD_out in the first cycle busy==0.
- Divide by zero (B==0 for DIV/DIVU): full DIV_CYCLES latency and busy profile, but HI and LO are left unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: HI<=A or LO<=A at the edge, when !cancel and !busy. Single cycle, no busy.
- MFHI/MFLO: no state change; MD_out is valid in the same cycle.
- md_op ignored while busy: start, MTHI and MTLO while busy are ignored (no error flag). The hazard unit guarantees this never happens: it stalls D when (start|busy) and the D instruction is an MD-class op.
- cancel:
  - Affects only the same-cycle md_op.
  - An operation already in flight always completes and commits; it belongs to an older instruction.
- Reset mid-operation: busy drops immediately, the pending result is discarded, and HI/LO are 0.
- No back-to-back overlap: a new start is accepted in the cycle busy is 0, including the cycle right after commit.

Decomposition:
- Shared package md_pkg:
  - md_op encodings (MD_NONE..MD_MFLO).
  - Default cycle constants.
  - A helper predicate is_md_op(op), reused by the hazard unit for its stall equation.
- One natural sub-module, md_calc: purely combinational 64-bit result generation from op/A/B, including the divide-by-zero flag.
- md_unit keeps the counter, pending registers, HI/LO and the control logic.

Test Plan:
- MULT with A=0xFFFFFFFF, B=2 -> busy high 5 cycles. HI=0xFFFFFFFF, LO=0xFFFFFFFE. MFLO in the first non-busy cycle gives MD_out=0xFFFFFFFE.
- MULTU with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. MFHI gives MD_out=1.
- DIV with A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with A=7, B=2 -> LO=3, HI=1.
- MTHI with A=0x12345678, then DIVU with B=0 -> busy 10 cycles, HI stays 0x12345678, LO unchanged.
- Cancel cases:
  - MULT with cancel=1 -> start=0, busy stays 0, HI/LO unchanged.
  - MTLO with cancel=1 -> LO unchanged.
  - cancel pulsed mid-busy -> result still commits.
- Reset mid-op and ignored ops:
  - Start DIV, drive reset=0 at cycle 4 -> busy=0, HI=LO=0 immediately, and nothing commits afterwards.
  - MTLO issued while busy -> LO unchanged.
